// File: rtl/tag_alloc_arbiter.sv
// Prefetches free tags from the dispatch tag FIFO, grants them round-robin to NUM_REQ
// requesters, and buffers CDB returns for FIFO write-back. Optional macro: TAG_ALLOC_STATS_EN.
module tag_alloc_arbiter #(
    parameter int TAG_WIDTH = 6,
    parameter int NUM_REQ   = 4,
    parameter int RET_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [TAG_WIDTH-1:0] grant_tag,
    input  logic [TAG_WIDTH-1:0] ret_tag,
    input  logic                 ret_valid,
    output logic                 ret_ovf,
    output logic                 ren_tf,
    input  logic [TAG_WIDTH-1:0] tagout_tf,
    input  logic                 ef_tf,
    input  logic                 ff_tf,
    output logic [TAG_WIDTH-1:0] cdb_tag_tf,
    output logic                 cdb_tag_tf_valid,
    output logic                 flush_tf,
`ifdef TAG_ALLOC_STATS_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic [1:0]           dbg_state
);
    localparam int RR_W = $clog2(NUM_REQ);
    localparam int RP_W = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
    localparam int RC_W = $clog2(RET_DEPTH) + 1;

    // Handshakes: req is a level; a grant is consumed at the clock edge it is shown.
    // ret_valid is a one-cycle pulse; ren_tf/cdb_tag_tf_valid are one-cycle FIFO strobes.
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t                 r_state, w_next_state;
    logic                   r_hold_valid;
    logic [TAG_WIDTH-1:0]   r_hold_tag;
    logic [RR_W-1:0]        r_rr_ptr;
    logic [RR_W-1:0]        w_winner;
    logic                   w_any_req;
    logic                   w_grant_fire;
    logic [TAG_WIDTH-1:0]   r_ret_mem [RET_DEPTH];
    logic [RP_W-1:0]        r_ret_wr, r_ret_rd;
    logic [RC_W-1:0]        r_ret_cnt;
    logic                   r_ret_ovf;
    logic                   w_ret_full, w_ret_empty, w_enq, w_deq;

    function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return RR_W'(s);
    endfunction

    function automatic logic [RP_W-1:0] ptr_inc(input logic [RP_W-1:0] p);
        return (p == RP_W'(RET_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan downward so the lowest offset from r_rr_ptr is the last (winning) assignment.
    always_comb begin
        w_winner  = r_rr_ptr;
        w_any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[rr_idx(r_rr_ptr, k)]) w_winner = rr_idx(r_rr_ptr, k);
        end
    end

    assign w_ret_full  = (r_ret_cnt == RC_W'(RET_DEPTH));
    assign w_ret_empty = (r_ret_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        ren_tf       = 1'b0;
        grant        = '0;
        w_grant_fire = 1'b0;
        case (r_state)
            S_FILL: begin
                if (!ef_tf && !w_ret_full) begin
                    ren_tf       = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: w_next_state = S_HELD;
            S_HELD: begin
                if (w_any_req && r_hold_valid) begin
                    grant        = NUM_REQ'(1) << w_winner;
                    w_grant_fire = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            default: w_next_state = S_FILL;
        endcase
        if (reset || flush) begin
            ren_tf       = 1'b0;
            grant        = '0;
            w_grant_fire = 1'b0;
            w_next_state = S_FILL;
        end
    end

    // The FIFO write only goes out when no read is issued, so the port never sees both.
    assign w_deq            = !w_ret_empty && !ren_tf && !ff_tf && !flush && !reset;
    assign w_enq            = ret_valid && !flush && !w_ret_full;
    assign cdb_tag_tf       = r_ret_mem[r_ret_rd];
    assign cdb_tag_tf_valid = w_deq;
    assign grant_tag        = r_hold_tag;
    assign ret_ovf          = r_ret_ovf;
    assign flush_tf         = flush;
    assign dbg_state        = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_hold_valid <= 1'b0;
            r_rr_ptr     <= '0;
            r_ret_wr     <= '0;
            r_ret_rd     <= '0;
            r_ret_cnt    <= '0;
            r_ret_ovf    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (flush) begin
                r_hold_valid <= 1'b0;
                r_ret_wr     <= '0;
                r_ret_rd     <= '0;
                r_ret_cnt    <= '0;
            end else begin
                if (r_state == S_WAIT) begin
                    r_hold_tag   <= tagout_tf;
                    r_hold_valid <= 1'b1;
                end else if (w_grant_fire) begin
                    r_hold_valid <= 1'b0;
                    r_rr_ptr     <= (w_winner == RR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                end
                if (w_enq) begin
                    r_ret_mem[r_ret_wr] <= ret_tag;
                    r_ret_wr            <= ptr_inc(r_ret_wr);
                end
                if (w_deq) r_ret_rd <= ptr_inc(r_ret_rd);
                if (ret_valid && w_ret_full) r_ret_ovf <= 1'b1;
                r_ret_cnt <= r_ret_cnt + RC_W'(w_enq) - RC_W'(w_deq);
            end
        end
    end

`ifdef TAG_ALLOC_STATS_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stall_cnt <= '0;
        end else if (w_any_req && !(|grant) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tag_alloc_arbiter.sv
// Bench for tag_alloc_arbiter: behavioural tag FIFO, queue-based reference model,
// directed test-plan steps followed by randomized traffic.
module tb_tag_alloc_arbiter;
  localparam int TW = 6;
  localparam int NR = 4;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          reset, flush, ret_valid, ef_tf, ff_tf;
  logic [NR-1:0] req;
  logic [TW-1:0] ret_tag, tagout_tf;
  logic [NR-1:0] grant;
  logic [TW-1:0] grant_tag, cdb_tag_tf;
  logic          ret_ovf, ren_tf, cdb_tag_tf_valid, flush_tf;
  logic [1:0]    dbg_state;
`ifdef TAG_ALLOC_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  tag_alloc_arbiter #(.TAG_WIDTH(TW), .NUM_REQ(NR), .RET_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req(req), .grant(grant),
    .grant_tag(grant_tag), .ret_tag(ret_tag), .ret_valid(ret_valid),
    .ret_ovf(ret_ovf), .ren_tf(ren_tf), .tagout_tf(tagout_tf), .ef_tf(ef_tf),
    .ff_tf(ff_tf), .cdb_tag_tf(cdb_tag_tf), .cdb_tag_tf_valid(cdb_tag_tf_valid),
    .flush_tf(flush_tf),
`ifdef TAG_ALLOC_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // external tag FIFO
  logic [TW-1:0] fifo_q[$];
  bit force_empty = 1'b0;
  bit force_full = 1'b0;

  // reference model: a tag is either being fetched, held, or absent
  bit            m_inflight, m_have, m_ovf;
  logic [TW-1:0] m_hold_tag;
  int            m_rr;
  int            m_stall;
  logic [TW-1:0] exp_q[$];

  // last sampled DUT outputs
  logic [NR-1:0] s_grant;
  logic [TW-1:0] s_tag, s_cdb;
  logic          s_ren, s_wr, s_ovf;
  logic [NR-1:0] glog_g[$];
  logic [TW-1:0] glog_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NR; k++) begin
      if (req[(m_rr + k) % NR]) return (m_rr + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit model_ren_next();
    return !m_inflight && !m_have && !force_empty && (fifo_q.size() > 0) && (exp_q.size() < RD);
  endfunction

  task automatic fill_fifo();
    fifo_q.delete();
    for (int i = 0; i < 64; i++) fifo_q.push_back(TW'(i));
  endtask

  // driver: one clock cycle with checks before the edge and model/FIFO update after it
  task automatic step();
    int w;
    logic [NR-1:0] e_grant;
    logic e_ren, e_wr;
    logic [TW-1:0] cur_tagout;
    bit full_before;
    ef_tf = force_empty || (fifo_q.size() == 0);
    ff_tf = force_full || (fifo_q.size() >= 64);
    @(negedge clk);
    e_ren = !reset && !flush && !m_inflight && !m_have && !ef_tf && (exp_q.size() < RD);
    w = (m_have && !reset && !flush) ? model_winner() : -1;
    e_grant = '0;
    if (w >= 0) e_grant[w] = 1'b1;
    e_wr = !reset && !flush && (exp_q.size() > 0) && !e_ren && !ff_tf;
    s_grant = grant; s_tag = grant_tag; s_ren = ren_tf; s_wr = cdb_tag_tf_valid;
    s_cdb = cdb_tag_tf; s_ovf = ret_ovf;
    cur_tagout = tagout_tf;
    check("grant", grant, e_grant);
    if (e_grant != '0) check("grant_tag", grant_tag, m_hold_tag);
    check("ren_tf", ren_tf, e_ren);
    check("cdb_valid", cdb_tag_tf_valid, e_wr);
    if (e_wr) check("cdb_tag", cdb_tag_tf, exp_q[0]);
    check("ret_ovf", ret_ovf, m_ovf);
    check("flush_tf", flush_tf, flush);
    check("no_rd_wr", ren_tf & cdb_tag_tf_valid, 0);
`ifdef TAG_ALLOC_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    if (s_grant != '0) begin glog_g.push_back(s_grant); glog_t.push_back(s_tag); end
    @(posedge clk);
    #1;
    full_before = exp_q.size() >= RD;
    if (reset) begin
      m_inflight = 0; m_have = 0; m_rr = 0; m_ovf = 0; m_stall = 0; exp_q.delete();
    end else if (flush) begin
      m_inflight = 0; m_have = 0; m_stall = 0; exp_q.delete();
    end else begin
      if (req != '0 && e_grant == '0) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
      if (e_wr) void'(exp_q.pop_front());
      if (ret_valid) begin
        if (full_before) m_ovf = 1;
        else exp_q.push_back(ret_tag);
      end
      if (w >= 0) begin
        m_have = 0; m_rr = (w + 1) % NR;
      end else if (m_inflight) begin
        m_have = 1; m_hold_tag = cur_tagout; m_inflight = 0;
      end
      if (e_ren) m_inflight = 1;
    end
    if (s_ren && fifo_q.size() > 0) tagout_tf = fifo_q.pop_front();
    else tagout_tf = TW'($urandom);
    if (s_wr) fifo_q.push_back(s_cdb);
  endtask

  initial begin
    int n, nwr, hits;
    bit found;
    logic [TW-1:0] exp_next;
    reset = 1; flush = 0; req = '0; ret_valid = 0; ret_tag = '0; tagout_tf = '0;
    m_inflight = 0; m_have = 0; m_rr = 0; m_ovf = 0; m_stall = 0; m_hold_tag = '0;
    fill_fifo();

    // reset, then first grants with req=0001
    req = 4'b0001;
    step();
    check("rst_grant", s_grant, 0);
    check("rst_ren", s_ren, 0);
    check("rst_wr", s_wr, 0);
    check("rst_ovf", s_ovf, 0);
    step();
    reset = 0;
    step(); check("tp1_c0_ren", s_ren, 1);
    step();
    step(); check("tp1_c2_grant", s_grant, 4'b0001); check("tp1_c2_tag", s_tag, 0);
    step();
    step();
    step(); check("tp1_c5_grant", s_grant, 4'b0001); check("tp1_c5_tag", s_tag, 1);

    // rotation with all requesters active
    fill_fifo();
    reset = 1; req = 4'b1111;
    step(); step();
    reset = 0;
    glog_g.delete(); glog_t.delete();
    for (int i = 0; i < 15; i++) step();
    check("tp2_count", (glog_g.size() >= 5), 1);
    for (int i = 0; i < 5 && i < glog_g.size(); i++) begin
      check("tp2_grant", glog_g[i], 1 << (i % NR));
      check("tp2_tag", glog_t[i], i);
    end

    // return arriving in a read cycle is written in the next non-read cycle
    n = 0;
    while (!model_ren_next() && n < 10) begin step(); n++; end
    ret_valid = 1; ret_tag = 6'd5;
    step(); check("tp3_ren", s_ren, 1); check("tp3_wr_same", s_wr, 0);
    ret_valid = 0;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_wr && s_cdb == 6'd5) found = 1;
    end
    check("tp3_written", found, 1);

    // overflow while FIFO full
    req = '0; force_full = 1;
    ret_valid = 1; ret_tag = 6'd10; step();
    ret_tag = 6'd11; step();
    ret_tag = 6'd9; step();
    ret_valid = 0;
    step(); check("tp4_ovf", s_ovf, 1);
    force_full = 0;
    nwr = 0;
    for (int i = 0; i < 6; i++) begin step(); if (s_wr) nwr++; end
    check("tp4_writes", nwr, 2);
    check("tp4_ovf_sticky", s_ovf, 1);

    // flush while holding a tag
    n = 0;
    while (!m_have && n < 10) begin step(); n++; end
    check("tp5_have", m_have, 1);
    flush = 1; req = 4'b0010;
    step(); check("tp5_flush_grant", s_grant, 0); check("tp5_flush_ren", s_ren, 0);
    flush = 0;
    exp_next = fifo_q[0];
`ifdef TAG_ALLOC_STATS_EN
    check("tp5_stall_zero", stall_cnt, 0);
`endif

    // empty FIFO: no reads, no grants
    force_empty = 1; req = 4'b0001;
    hits = 0;
    for (int i = 0; i < 10; i++) begin step(); if (s_ren || s_grant != '0) hits++; end
    check("tp6_idle", hits, 0);
`ifdef TAG_ALLOC_STATS_EN
    check("tp6_stall", stall_cnt, 10);
`endif
    force_empty = 0;
    found = 0; n = 0;
    while (!found && n < 10) begin
      step(); n++;
      if (s_grant != '0) begin found = 1; check("tp5_next_tag", s_tag, exp_next); end
    end
    check("tp5_regrant", found, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req = NR'($urandom);
      ret_valid = ($urandom_range(0, 2) == 0);
      ret_tag = TW'($urandom);
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) force_full = ~force_full;
      if ($urandom_range(0, 11) == 0) force_empty = ~force_empty;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
